// File: rtl/ram_128x21_ecc_scrubber.sv
// ram_128x21_ecc_scrubber
//   Background ECC scrubber sitting in front of a two-port RAM with built-in
//   SEC/DED correction. It owns the RAM address/data/write pins. It forwards
//   client traffic unchanged and uses idle cycles to walk every address. Each
//   scrub read consumes the RAM's SB_CORRECT / DB_DETECT flags. A corrected
//   word is written back so the stored copy is clean again.
//
// Ports
//   CLK, RESETN          clock (rising edge), asynchronous active-low reset
//   scrub_en             1 = scrubbing allowed, 0 = pure pass-through
//   cl_wen/waddr/wd      client write port (always wins over the scrubber)
//   cl_ren/raddr         client read port  (always wins over the scrubber)
//   cl_rd                client read data, straight from ram_rd
//   ram_wen/waddr/wd     to RAM write pins
//   ram_raddr            to RAM read address
//   ram_rd/ram_sb/ram_db from RAM, valid the cycle after a read address
//   err_clr              clears both counters, db_flag and db_addr
//   sb_count, db_count   saturating error counters
//   db_flag, db_addr     sticky flag and address of the first double-bit error
//   pass_done            one-cycle pulse when the scrub pointer wraps to 0
//   state_dbg            current FSM state (0 WAIT,1 READ,2 CHECK,3 WB,4 ADV)
//
// Strobe protocol: cl_wen and cl_ren are single-cycle commands with no
// back-pressure. They are forwarded to the RAM in the same cycle they are
// high and are never stalled. The scrubber yields whenever either strobe is
// set. It never issues a read alongside a client write, because the RAM's
// SB/DB flags would then be ambiguous.
module ram_128x21_ecc_scrubber #(
  parameter int AW       = 7,
  parameter int DW       = 21,
  parameter int INTERVAL = 1024,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             scrub_en,
  input  logic             cl_wen,
  input  logic [AW-1:0]    cl_waddr,
  input  logic [DW-1:0]    cl_wd,
  input  logic             cl_ren,
  input  logic [AW-1:0]    cl_raddr,
  output logic [DW-1:0]    cl_rd,
  output logic             ram_wen,
  output logic [AW-1:0]    ram_waddr,
  output logic [DW-1:0]    ram_wd,
  output logic [AW-1:0]    ram_raddr,
  input  logic [DW-1:0]    ram_rd,
  input  logic             ram_sb,
  input  logic             ram_db,
  input  logic             err_clr,
  output logic [CNT_W-1:0] sb_count,
  output logic [CNT_W-1:0] db_count,
  output logic             db_flag,
  output logic [AW-1:0]    db_addr,
  output logic             pass_done,
  output logic [2:0]       state_dbg
);

  localparam int TW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(INTERVAL - 1);

  typedef enum logic [2:0] {
    ST_WAIT  = 3'd0,
    ST_READ  = 3'd1,
    ST_CHECK = 3'd2,
    ST_WB    = 3'd3,
    ST_ADV   = 3'd4
  } state_t;

  state_t        state;
  logic [AW-1:0] ptr;
  logic [TW-1:0] timer;
  logic [DW-1:0] hold_rd;

  // A client write to the word being scrubbed makes the held copy stale.
  logic cl_hit;
  logic rd_issue;
  logic wb_fire;

  assign cl_hit   = cl_wen && (cl_waddr == ptr);
  assign rd_issue = scrub_en && (state == ST_READ) && !cl_ren && !cl_wen;
  assign wb_fire  = scrub_en && (state == ST_WB) && !cl_wen;

  assign cl_rd     = ram_rd;
  assign state_dbg = state;

  // Pin mux. The read address shows the scrub pointer whenever the client
  // is not reading, so a scrub read needs no extra address register.
  always_comb begin
    ram_wen   = 1'b0;
    ram_waddr = '0;
    ram_wd    = '0;
    if (cl_wen) begin
      ram_wen   = 1'b1;
      ram_waddr = cl_waddr;
      ram_wd    = cl_wd;
    end else if (wb_fire) begin
      ram_wen   = 1'b1;
      ram_waddr = ptr;
      ram_wd    = hold_rd;
    end
    ram_raddr = cl_ren ? cl_raddr : ptr;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state     <= ST_WAIT;
      ptr       <= '0;
      timer     <= TIMER_RELOAD;
      hold_rd   <= '0;
      sb_count  <= '0;
      db_count  <= '0;
      db_flag   <= 1'b0;
      db_addr   <= '0;
      pass_done <= 1'b0;
    end else begin
      pass_done <= 1'b0;
      if (!scrub_en) begin
        // Abandon any scan in flight; the pointer is kept so the next
        // enable resumes where this one stopped.
        state <= ST_WAIT;
        timer <= TIMER_RELOAD;
      end else begin
        unique case (state)
          ST_WAIT: begin
            if (timer == '0) state <= ST_READ;
            else             timer <= timer - 1'b1;
          end
          ST_READ: begin
            if (rd_issue) state <= ST_CHECK;
          end
          ST_CHECK: begin
            hold_rd <= ram_rd;
            if (ram_db) begin
              // Uncorrectable: nothing valid to write back.
              if (db_count != {CNT_W{1'b1}}) db_count <= db_count + 1'b1;
              if (!db_flag) begin
                db_flag <= 1'b1;
                db_addr <= ptr;
              end
              state <= ST_ADV;
            end else if (ram_sb && !cl_hit) begin
              state <= ST_WB;
            end else begin
              state <= ST_ADV;
            end
          end
          ST_WB: begin
            if (cl_hit) begin
              state <= ST_ADV;
            end else if (!cl_wen) begin
              if (sb_count != {CNT_W{1'b1}}) sb_count <= sb_count + 1'b1;
              state <= ST_ADV;
            end
          end
          ST_ADV: begin
            pass_done <= (ptr == {AW{1'b1}});
            ptr       <= ptr + 1'b1;
            timer     <= TIMER_RELOAD;
            state     <= ST_WAIT;
          end
          default: state <= ST_WAIT;
        endcase
      end
      // Clear is applied last so it overrides a same-edge increment.
      if (err_clr) begin
        sb_count <= '0;
        db_count <= '0;
        db_flag  <= 1'b0;
        db_addr  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ram_128x21_ecc_scrubber.sv
// Testbench for ram_128x21_ecc_scrubber: behavioural RAM with error
// injection, a scan-order reference model and a write-back scoreboard.
module tb_ram_128x21_ecc_scrubber;

  localparam int AW       = 7;
  localparam int DW       = 21;
  localparam int INTERVAL = 4;
  localparam int CNT_W    = 4;
  localparam int DEPTH    = 1 << AW;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             CLK;
  logic             RESETN;
  logic             scrub_en;
  logic             cl_wen;
  logic [AW-1:0]    cl_waddr;
  logic [DW-1:0]    cl_wd;
  logic             cl_ren;
  logic [AW-1:0]    cl_raddr;
  logic [DW-1:0]    cl_rd;
  logic             ram_wen;
  logic [AW-1:0]    ram_waddr;
  logic [DW-1:0]    ram_wd;
  logic [AW-1:0]    ram_raddr;
  logic [DW-1:0]    ram_rd;
  logic             ram_sb;
  logic             ram_db;
  logic             err_clr;
  logic [CNT_W-1:0] sb_count;
  logic [CNT_W-1:0] db_count;
  logic             db_flag;
  logic [AW-1:0]    db_addr;
  logic             pass_done;
  logic [2:0]       state_dbg;

  ram_128x21_ecc_scrubber #(
    .AW(AW), .DW(DW), .INTERVAL(INTERVAL), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RESETN(RESETN), .scrub_en(scrub_en),
    .cl_wen(cl_wen), .cl_waddr(cl_waddr), .cl_wd(cl_wd),
    .cl_ren(cl_ren), .cl_raddr(cl_raddr), .cl_rd(cl_rd),
    .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wd(ram_wd),
    .ram_raddr(ram_raddr), .ram_rd(ram_rd), .ram_sb(ram_sb), .ram_db(ram_db),
    .err_clr(err_clr), .sb_count(sb_count), .db_count(db_count),
    .db_flag(db_flag), .db_addr(db_addr), .pass_done(pass_done),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- behavioural RAM ----------------
  logic [DW-1:0] mem    [DEPTH];
  logic          sb_inj [DEPTH];
  logic          db_inj [DEPTH];

  always @(posedge CLK) begin
    ram_rd <= mem[ram_raddr];
    ram_sb <= sb_inj[ram_raddr];
    ram_db <= db_inj[ram_raddr];
    if (ram_wen) mem[ram_waddr] <= ram_wd;
  end

  // ---------------- checking ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [DW-1:0]    shadow [DEPTH];  // what the client last wrote
  logic [AW+DW-1:0] exp_q[$];        // expected scrub write-backs {addr,data}
  int               exp_cyc_q[$];    // cycle of the read behind each entry
  logic [AW-1:0]    model_ptr = '0;
  int               exp_sb = 0, exp_db = 0;
  logic             exp_flag = 1'b0;
  logic [AW-1:0]    exp_dba = '0;
  logic             pend = 1'b0;
  logic [AW-1:0]    pend_addr = '0;
  int               pend_cyc = 0;
  int               cyc = 0, rd_issued = 0, wraps_exp = 0, pass_seen = 0;
  logic [AW+DW-1:0] mon_e;
  int               mon_c;

  always @(negedge CLK) begin
    cyc++;
    if (!RESETN) begin
      model_ptr = '0; exp_sb = 0; exp_db = 0; exp_flag = 1'b0; exp_dba = '0;
      pend = 1'b0;
      exp_q.delete();
      exp_cyc_q.delete();
    end else begin
      // Cycle after a read: the corrected word is owed back unless the
      // client overwrites the same address right now.
      if (pend) begin
        pend = 1'b0;
        if (!(cl_wen && cl_waddr == pend_addr)) begin
          exp_q.push_back({pend_addr, shadow[pend_addr]});
          exp_cyc_q.push_back(pend_cyc);
          if (exp_sb < CNT_MAX) exp_sb++;
        end
      end
      if (ram_wen && !cl_wen) begin
        check("wb_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          mon_c = exp_cyc_q.pop_front();
          check("wb_addr", 32'(ram_waddr), 32'(mon_e[AW+DW-1:DW]));
          check("wb_data", 32'(ram_wd), 32'(mon_e[DW-1:0]));
          check("wb_latency", 32'(cyc - mon_c), 32'd2);
        end
      end
      if (scrub_en && !cl_ren && !cl_wen && state_dbg == 3'd1) begin
        check("rd_addr", 32'(ram_raddr), 32'(model_ptr));
        rd_issued++;
        if (db_inj[model_ptr]) begin
          if (exp_db < CNT_MAX) exp_db++;
          if (!exp_flag) begin
            exp_flag = 1'b1;
            exp_dba  = model_ptr;
          end
        end else if (sb_inj[model_ptr]) begin
          pend = 1'b1; pend_addr = model_ptr; pend_cyc = cyc;
        end
        if (model_ptr == AW'(DEPTH - 1)) wraps_exp++;
        model_ptr = model_ptr + 1'b1;
      end
      if (pass_done) pass_seen++;
      if (err_clr) begin
        exp_sb = 0; exp_db = 0; exp_flag = 1'b0; exp_dba = '0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return DW'($urandom);
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    return AW'($urandom);
  endfunction

  task automatic client_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cl_wen = 1'b1; cl_waddr = a; cl_wd = d;
    shadow[a] = d;
    tick();
    cl_wen = 1'b0;
  endtask

  task automatic client_read_check(input string tag, input logic [AW-1:0] a);
    cl_ren = 1'b1; cl_raddr = a;
    tick();
    cl_ren = 1'b0;
    check(tag, 32'(cl_rd), 32'(shadow[a]));
  endtask

  // Scrub until n more reads have issued, let the last one retire, then pause.
  task automatic wait_reads(input int n);
    int target;
    int k;
    target = rd_issued + n;
    k = 0;
    scrub_en = 1'b1;
    while (rd_issued < target && k < n * (INTERVAL + 8) + 50) begin
      tick();
      k++;
    end
    check("reads_in_time", 32'(rd_issued >= target), 32'd1);
    repeat (4) tick();
    scrub_en = 1'b0;
    tick();
  endtask

  task automatic wait_state(input logic [2:0] s);
    int k;
    k = 0;
    while (state_dbg != s && k < 100) begin
      tick();
      k++;
    end
    check("state_reached", 32'(state_dbg), 32'(s));
  endtask

  task automatic check_status(input string tag);
    check({tag, "_sb"},   32'(sb_count), 32'(exp_sb));
    check({tag, "_db"},   32'(db_count), 32'(exp_db));
    check({tag, "_flag"}, 32'(db_flag),  32'(exp_flag));
    check({tag, "_addr"}, 32'(db_addr),  32'(exp_dba));
  endtask

  task automatic clear_inj();
    for (int i = 0; i < DEPTH; i++) begin
      sb_inj[i] = 1'b0;
      db_inj[i] = 1'b0;
    end
  endtask

  task automatic pulse_clear();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_sb",   32'(sb_count), 32'd0);
    check("clr_db",   32'(db_count), 32'd0);
    check("clr_flag", 32'(db_flag),  32'd0);
    check("clr_addr", 32'(db_addr),  32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [AW-1:0] p, a;
  logic [DW-1:0] nd;
  logic          ren;
  int            n_sb, target, k;

  initial begin
    RESETN = 1'b1; scrub_en = 1'b0; cl_wen = 1'b0; cl_waddr = '0; cl_wd = '0;
    cl_ren = 1'b0; cl_raddr = '0; err_clr = 1'b0;
    clear_inj();
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    #3 RESETN = 1'b0;
    repeat (3) tick();

    // reset state
    check("rst_state",  32'(state_dbg), 32'd0);
    check("rst_wen",    32'(ram_wen),   32'd0);
    check("rst_raddr",  32'(ram_raddr), 32'd0);
    check("rst_sb",     32'(sb_count),  32'd0);
    check("rst_db",     32'(db_count),  32'd0);
    check("rst_flag",   32'(db_flag),   32'd0);
    check("rst_dbaddr", 32'(db_addr),   32'd0);
    check("rst_pass",   32'(pass_done), 32'd0);
    RESETN = 1'b1;
    tick();

    // fill through the client port (pass-through while scrub_en=0)
    for (int i = 0; i < DEPTH; i++)
      client_write(AW'(i), (i == 5) ? 21'h0ABCDE : rnd_data());
    for (int i = 0; i < 8; i++) client_read_check("fill_rd", rnd_addr());

    // clean pass: no write-backs, one wrap, pointer back at 0
    wait_reads(DEPTH);
    check("p1_pass_cnt", 32'(pass_seen), 32'd1);
    check("p1_pass_mdl", 32'(pass_seen), 32'(wraps_exp));
    check("p1_ptr",      32'(ram_raddr), 32'd0);
    check_status("p1");

    // SB at 0x05 plus random SBs, DB at 0x10 then 0x20
    sb_inj[5] = 1'b1;
    for (int i = 0; i < 3; i++) sb_inj[$urandom_range(64, DEPTH - 1)] = 1'b1;
    db_inj[7'h10] = 1'b1;
    db_inj[7'h20] = 1'b1;
    n_sb = 0;
    for (int i = 0; i < DEPTH; i++) if (sb_inj[i] && !db_inj[i]) n_sb++;
    wait_reads(DEPTH);
    check("p2_sb_n",   32'(sb_count),  32'(n_sb));
    check("p2_db_n",   32'(db_count),  32'd2);
    check("p2_flag",   32'(db_flag),   32'd1);
    check("p2_dbaddr", 32'(db_addr),   32'h10);
    check("p2_pass",   32'(pass_seen), 32'd2);
    check_status("p2");
    cl_ren = 1'b1; cl_raddr = 7'h05;
    tick();
    cl_ren = 1'b0;
    check("p2_data05", 32'(cl_rd), 32'h0ABCDE);
    clear_inj();
    pulse_clear();

    // random pass: random errors, random client reads stealing READ slots
    for (int i = 0; i < 10; i++) begin
      a = rnd_addr();
      if ($urandom_range(0, 1) == 1) sb_inj[a] = 1'b1;
      else                           db_inj[a] = 1'b1;
    end
    scrub_en = 1'b1;
    target = rd_issued + DEPTH;
    k = 0;
    while (rd_issued < target && k < 4000) begin
      ren = ($urandom_range(0, 2) == 0);
      a = rnd_addr();
      cl_ren = ren; cl_raddr = a;
      tick();
      k++;
      if (ren) check("rand_cl_rd", 32'(cl_rd), 32'(shadow[a]));
    end
    cl_ren = 1'b0;
    check("rand_reads_in_time", 32'(rd_issued >= target), 32'd1);
    repeat (4) tick();
    scrub_en = 1'b0;
    tick();
    check_status("rand");
    clear_inj();
    pulse_clear();

    // saturation of both counters
    for (int i = 0; i < 20; i++) begin
      db_inj[8'h30 + i] = 1'b1;
      sb_inj[8'h50 + i] = 1'b1;
    end
    wait_reads(DEPTH);
    check("sat_db",     32'(db_count), 32'(CNT_MAX));
    check("sat_sb",     32'(sb_count), 32'(CNT_MAX));
    check("sat_dbaddr", 32'(db_addr),  32'h30);
    check_status("sat");
    clear_inj();
    pulse_clear();

    // clear held across DB detections: clear must win every time
    for (int i = 0; i < 8; i++) db_inj[model_ptr + AW'(i)] = 1'b1;
    err_clr = 1'b1;
    wait_reads(8);
    err_clr = 1'b0;
    check("clrwin_db",   32'(db_count), 32'd0);
    check("clrwin_flag", 32'(db_flag),  32'd0);
    check_status("clrwin");
    clear_inj();

    // client writes the scrubbed word while it is being checked
    p = model_ptr;
    sb_inj[p] = 1'b1;
    scrub_en = 1'b1;
    wait_state(3'd2);
    nd = rnd_data();
    cl_wen = 1'b1; cl_waddr = p; cl_wd = nd; shadow[p] = nd;
    tick();
    cl_wen = 1'b0;
    repeat (4) tick();
    scrub_en = 1'b0;
    tick();
    sb_inj[p] = 1'b0;
    check("abort_sb", 32'(sb_count), 32'd0);
    check_status("abort");
    client_read_check("abort_data", p);

    // client reads hold off the scrub read for 50 cycles
    scrub_en = 1'b1;
    wait_state(3'd1);
    a = rnd_addr();
    cl_ren = 1'b1; cl_raddr = a;
    for (int i = 0; i < 50; i++) begin
      tick();
      check("stall_cl_rd", 32'(cl_rd),     32'(shadow[a]));
      check("stall_raddr", 32'(ram_raddr), 32'(a));
      check("stall_state", 32'(state_dbg), 32'd1);
      a = rnd_addr();
      cl_raddr = a;
    end
    cl_ren = 1'b0;
    wait_reads(1);

    // reset during write-back: write dropped, scan restarts at 0
    p = model_ptr;
    sb_inj[p] = 1'b1;
    scrub_en = 1'b1;
    wait_state(3'd3);
    RESETN = 1'b0;
    #1;
    check("rstwb_wen",   32'(ram_wen),   32'd0);
    check("rstwb_state", 32'(state_dbg), 32'd0);
    tick();
    check("rstwb_raddr", 32'(ram_raddr), 32'd0);
    check("rstwb_pass",  32'(pass_done), 32'd0);
    check("rstwb_sb",    32'(sb_count),  32'd0);
    sb_inj[p] = 1'b0;
    RESETN = 1'b1;
    tick();
    wait_reads(2);
    check_status("post_rst");

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("pass_total",    32'(pass_seen),    32'(wraps_exp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
